// File: rtl/mem_access_if.sv
// Data-memory bus: mem_access drives the request side (master), the memory answers (slave).
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory stage: one load/store per transaction over a req/gnt/rvalid bus, store lane formatting, load extension.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and complete next cycle with o_misaligned.
module mem_access #(
  parameter int TIMEOUT = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [2:0]   funct3,
  input  logic [31:0]  addr,
  input  logic [31:0]  store_data,
  output logic         o_busy,
  mem_access_if.master dmem,
  output logic         o_valid,
  output logic [31:0]  mem_data_out,
  output logic         o_bus_err,
  output logic         o_misaligned
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   addr_q, data_q;
  logic [2:0]    f3_q;
  logic          we_q;
  logic          accept, done, capture, abort, trap;
  size_t         size_q;

  // Unlisted funct3 codes fall back to word access.
  function automatic size_t op_size(logic [2:0] f3, logic st);
    size_t s;
    if (st) s = (f3 == 3'b000) ? SZ_B : (f3 == 3'b001) ? SZ_H : SZ_W;
    else    s = (f3[1:0] == 2'b00) ? SZ_B : (f3[1:0] == 2'b01) ? SZ_H : SZ_W;
    return s;
  endfunction

  function automatic logic [31:0] fmt_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (op_size(f3, 1'b0))
      SZ_B:    r = {{24{b[7] & ~f3[2]}}, b};
      SZ_H:    r = {{16{h[15] & ~f3[2]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef MISALIGN_TRAP_EN
  size_t size_in;
  logic  mis_in;
  assign size_in = op_size(funct3, mem_write);
  assign mis_in  = (size_in == SZ_H && addr[0]) || (size_in == SZ_W && addr[1:0] != 2'b00);
`endif

  assign size_q          = op_size(f3_q, we_q);
  assign o_busy          = (state != IDLE);
  assign dmem.dmem_req   = (state == REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};

  always_comb begin
    dmem.dmem_wdata = data_q;
    dmem.dmem_wmask = 4'b1111;
    case (size_q)
      SZ_B: begin
        dmem.dmem_wdata = {4{data_q[7:0]}};
        dmem.dmem_wmask = 4'b0001 << addr_q[1:0];
      end
      SZ_H: begin
        dmem.dmem_wdata = {2{data_q[15:0]}};
        dmem.dmem_wmask = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: ;
    endcase
    if (!we_q) dmem.dmem_wmask = 4'b0000;
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    done    = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    trap    = 1'b0;
    case (state)
      IDLE: if (i_valid && (mem_read || mem_write)) begin
        accept = 1'b1;
        cnt_d  = '0;
`ifdef MISALIGN_TRAP_EN
        if (mis_in) trap = 1'b1;
        else        state_d = REQ;
`else
        state_d = REQ;
`endif
      end
      REQ: if (dmem.dmem_gnt) begin
        if (we_q) begin
          done = 1'b1; state_d = IDLE;
        end else if (dmem.dmem_rvalid) begin
          done = 1'b1; capture = 1'b1; state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      RESP: if (dmem.dmem_rvalid) begin
        done = 1'b1; capture = 1'b1; state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A completion on the last allowed cycle still wins over the abort.
    if (state != IDLE && !done) begin
      if (cnt == CW'(TIMEOUT - 1)) begin
        abort = 1'b1; state_d = IDLE;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      o_valid      <= 1'b0;
      o_bus_err    <= 1'b0;
      o_misaligned <= 1'b0;
      mem_data_out <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        addr_q <= addr;
        data_q <= store_data;
        f3_q   <= funct3;
        we_q   <= mem_write;
      end
      o_valid      <= done | abort | trap;
      o_bus_err    <= abort;
      o_misaligned <= trap;
      if (capture)            mem_data_out <= fmt_load(f3_q, addr_q[1:0], dmem.dmem_rdata);
      else if (abort || trap) mem_data_out <= '0;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed spec cases plus random back-to-back traffic
// against an arithmetic reference model of lanes, extension and latency.
module tb_mem_access;
  localparam int TMO = 8;

  logic        i_clk = 1'b0, i_rst = 1'b0;
  logic        i_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, store_data = '0;
  logic        o_busy, o_valid, o_bus_err, o_misaligned;
  logic [31:0] mem_data_out;
  int          n_checks = 0, n_fail = 0;

  mem_access_if dmem();

  mem_access #(.TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
    .o_busy(o_busy), .dmem(dmem), .o_valid(o_valid), .mem_data_out(mem_data_out),
    .o_bus_err(o_bus_err), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  // ---- reference model ----
  function automatic int ld_size(logic [2:0] f3);
    return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
  endfunction
  function automatic int st_size(logic [2:0] f3);
    return (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
  endfunction
  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    int sz, sh;
    logic [31:0] v;
    sz = ld_size(f3);
    if (sz == 4) return rd;
    sh = (sz == 1) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
    v  = (rd >> sh) & ((sz == 1) ? 32'hFF : 32'hFFFF);
    if (f3 < 4 && v >= ((sz == 1) ? 32'd128 : 32'd32768)) v = v - ((sz == 1) ? 32'd256 : 32'd65536);
    return v;
  endfunction
  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
    int sz;
    sz = st_size(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction
  function automatic logic [3:0] model_wmask(logic [2:0] f3, logic [31:0] a);
    int sz;
    sz = st_size(f3);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'hF;
  endfunction
  function automatic logic model_mis(logic rd, logic [2:0] f3, logic [31:0] a);
    int sz;
    sz = rd ? ld_size(f3) : st_size(f3);
    return (a % sz) != 0;
  endfunction

  // Drives one transaction from a negedge; memory grants after gw request cycles and
  // returns rvalid rw cycles after the grant. Returns at the negedge showing o_valid.
  task automatic do_txn(input logic rd, input logic [2:0] f3, input logic [31:0] a, d,
                        input int gw, rw, input logic [31:0] rdat,
                        output int lat, output logic [31:0] out, output logic err, mis,
                        output logic [31:0] q_addr, q_wdata, output logic q_we,
                        output logic [3:0] q_wmask, output int nreq, output logic ok);
    int respn;
    bit granted;
    respn = 0; granted = 0; lat = -1; out = '0; err = 0; mis = 0; ok = 1; nreq = 0;
    q_addr = '0; q_wdata = '0; q_we = 0; q_wmask = '0;
    i_valid = 1; mem_read = rd; mem_write = !rd; funct3 = f3; addr = a; store_data = d;
    dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0; dmem.dmem_rdata = rdat;
    @(negedge i_clk);
    i_valid = 0; mem_read = 0; mem_write = 0;
    addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    for (int c = 1; c <= TMO + 20; c++) begin
      dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0;
      if (o_valid) begin
        lat = c; out = mem_data_out; err = o_bus_err; mis = o_misaligned;
        if (o_busy) ok = 0;
        break;
      end
      if (!o_busy) ok = 0;
      if (dmem.dmem_req) begin
        if (nreq == 0) begin
          q_addr = dmem.dmem_addr; q_wdata = dmem.dmem_wdata;
          q_we = dmem.dmem_we; q_wmask = dmem.dmem_wmask;
        end else if (dmem.dmem_addr !== q_addr || dmem.dmem_wdata !== q_wdata ||
                     dmem.dmem_we !== q_we || dmem.dmem_wmask !== q_wmask) ok = 0;
        if (nreq == gw) begin
          dmem.dmem_gnt = 1; granted = 1;
          if (rd && rw == 0) dmem.dmem_rvalid = 1;
        end
        nreq++;
      end else if (granted && rd) begin
        if (respn == rw - 1) dmem.dmem_rvalid = 1;
        respn++;
      end
      @(negedge i_clk);
    end
    dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({o_busy, o_valid, o_bus_err, o_misaligned, dmem.dmem_req, dmem.dmem_we, mem_data_out,
         dmem.dmem_addr, dmem.dmem_wdata, dmem.dmem_wmask} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b valid=%b req=%b data=%h wmask=%b, all must be 0",
                         o_busy, o_valid, dmem.dmem_req, mem_data_out, dmem.dmem_wmask);
    end
    @(negedge i_clk); i_rst = 1;
    i_valid = 1; dmem.dmem_gnt = 1; dmem.dmem_rvalid = 1;
    @(negedge i_clk);
    n_checks++;
    if ({o_busy, o_valid, dmem.dmem_req} !== 3'b000) begin
      n_fail++; $display("FAIL ignored_valid: busy=%b valid=%b req=%b, expected 000", o_busy, o_valid, dmem.dmem_req);
    end
    i_valid = 0; dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0;
    @(negedge i_clk);
  endtask

  task automatic test_store_word();
    int lat, nreq; logic [31:0] out, qa, qd; logic err, mis, qwe, ok; logic [3:0] qm;
    do_txn(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, lat, out, err, mis, qa, qd, qwe, qm, nreq, ok);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    n_checks++; if (qwe !== 1'b1 || qm !== 4'b1111) begin n_fail++; $display("FAIL sw_we_mask: we=%b mask=%b expected 1 1111", qwe, qm); end
    n_checks++; if (qa !== 32'h100 || qd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_addr_data: addr=%h data=%h expected 100 deadbeef", qa, qd); end
    n_checks++; if (err !== 1'b0 || !ok) begin n_fail++; $display("FAIL sw_flags: err=%b busy/stable=%b expected 0 1", err, ok); end
  endtask

  task automatic test_load_byte();
    int lat, nreq; logic [31:0] out, qa, qd; logic err, mis, qwe, ok; logic [3:0] qm;
    do_txn(1'b1, 3'b000, 32'h103, 32'h0, 3, 0, 32'h80FFFF7F, lat, out, err, mis, qa, qd, qwe, qm, nreq, ok);
    n_checks++; if (out !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", out); end
    n_checks++; if (lat !== 5 || !ok) begin n_fail++; $display("FAIL lb_latency_busy: lat=%0d ok=%b expected 5 1", lat, ok); end
    do_txn(1'b1, 3'b100, 32'h103, 32'h0, 3, 0, 32'h80FFFF7F, lat, out, err, mis, qa, qd, qwe, qm, nreq, ok);
    n_checks++; if (out !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h expected 00000080", out); end
    n_checks++; if (qa !== 32'h100 || qwe !== 1'b0) begin n_fail++; $display("FAIL lbu_addr: addr=%h we=%b expected 100 0", qa, qwe); end
  endtask

  task automatic test_store_half();
    int lat, nreq; logic [31:0] out, qa, qd; logic err, mis, qwe, ok; logic [3:0] qm;
    do_txn(1'b0, 3'b001, 32'h202, 32'h0000ABCD, 1, 0, 32'h0, lat, out, err, mis, qa, qd, qwe, qm, nreq, ok);
    n_checks++; if (qd !== 32'hABCDABCD || qm !== 4'b1100) begin n_fail++; $display("FAIL sh_lanes: data=%h mask=%b expected abcdabcd 1100", qd, qm); end
    n_checks++; if (lat !== 3 || !ok) begin n_fail++; $display("FAIL sh_latency_stable: lat=%0d ok=%b expected 3 1", lat, ok); end
  endtask

  task automatic test_timeout();
    int lat, nreq; logic [31:0] out, qa, qd; logic err, mis, qwe, ok; logic [3:0] qm;
    do_txn(1'b1, 3'b010, 32'h300, 32'h0, 0, 1000, 32'h12345678, lat, out, err, mis, qa, qd, qwe, qm, nreq, ok);
    n_checks++; if (lat !== TMO + 1 || err !== 1'b1) begin n_fail++; $display("FAIL timeout_resp: lat=%0d err=%b expected %0d 1", lat, err, TMO + 1); end
    n_checks++; if (out !== 32'h0 || dmem.dmem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_resp_data: data=%h req=%b expected 0 0", out, dmem.dmem_req); end
    do_txn(1'b1, 3'b010, 32'h304, 32'h0, -1, 0, 32'h12345678, lat, out, err, mis, qa, qd, qwe, qm, nreq, ok);
    n_checks++; if (lat !== TMO + 1 || err !== 1'b1 || nreq !== TMO) begin n_fail++; $display("FAIL timeout_req: lat=%0d err=%b reqcycles=%0d expected %0d 1 %0d", lat, err, nreq, TMO + 1, TMO); end
  endtask

  task automatic test_misaligned();
    int lat, nreq; logic [31:0] out, qa, qd; logic err, mis, qwe, ok; logic [3:0] qm;
    do_txn(1'b1, 3'b010, 32'h101, 32'h0, 0, 0, 32'hCAFEF00D, lat, out, err, mis, qa, qd, qwe, qm, nreq, ok);
`ifdef MISALIGN_TRAP_EN
    n_checks++; if (nreq !== 0 || mis !== 1'b1 || lat !== 1) begin n_fail++; $display("FAIL mis_trap: reqcycles=%0d mis=%b lat=%0d expected 0 1 1", nreq, mis, lat); end
    n_checks++; if (out !== 32'h0) begin n_fail++; $display("FAIL mis_trap_data: got %h expected 0", out); end
`else
    n_checks++; if (qa !== 32'h100 || mis !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL mis_plain: addr=%h mis=%b lat=%0d expected 100 0 2", qa, mis, lat); end
    n_checks++; if (out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_plain_data: got %h expected cafef00d", out); end
`endif
  endtask

  task automatic test_back_to_back();
    int lat, nreq, gw, rw, elat; logic [31:0] out, qa, qd, a, d, rdat; logic err, mis, qwe, ok, rd, emis;
    logic [3:0] qm; logic [2:0] f3;
    for (int k = 0; k < 40; k++) begin
      rd = 1'($urandom_range(0, 1)); f3 = 3'($urandom); a = $urandom; d = $urandom; rdat = $urandom;
      gw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
`ifdef MISALIGN_TRAP_EN
      emis = model_mis(rd, f3, a);
`else
      emis = 1'b0;
`endif
      elat = emis ? 1 : (rd ? 2 + gw + rw : 2 + gw);
      do_txn(rd, f3, a, d, gw, rw, rdat, lat, out, err, mis, qa, qd, qwe, qm, nreq, ok);
      n_checks++;
      if (lat !== elat || mis !== emis || err !== 1'b0 || !ok) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: lat=%0d mis=%b err=%b ok=%b expected %0d %b 0 1", k, lat, mis, err, ok, elat, emis);
      end
      if (!emis) begin
        n_checks++;
        if (rd && (out !== model_load(f3, a, rdat) || qwe !== 1'b0)) begin
          n_fail++; $display("FAIL rand_load[%0d]: f3=%0d a=%h data=%h expected %h", k, f3, a, out, model_load(f3, a, rdat));
        end else if (!rd && (qd !== model_wdata(f3, d) || qm !== model_wmask(f3, a) || qwe !== 1'b1)) begin
          n_fail++; $display("FAIL rand_store[%0d]: f3=%0d a=%h wdata=%h mask=%b expected %h %b", k, f3, a, qd, qm, model_wdata(f3, d), model_wmask(f3, a));
        end
        n_checks++;
        if (qa !== (a & 32'hFFFFFFFC)) begin n_fail++; $display("FAIL rand_addr[%0d]: got %h expected %h", k, qa, a & 32'hFFFFFFFC); end
      end
    end
  endtask

  task automatic test_reset_during_resp();
    i_valid = 1; mem_read = 1; funct3 = 3'b010; addr = 32'h40;
    @(negedge i_clk); i_valid = 0; mem_read = 0; dmem.dmem_gnt = 1;
    @(negedge i_clk); dmem.dmem_gnt = 0;
    n_checks++; if (o_busy !== 1'b1 || dmem.dmem_req !== 1'b0) begin n_fail++; $display("FAIL resp_state: busy=%b req=%b expected 1 0", o_busy, dmem.dmem_req); end
    #2 i_rst = 0; #1;
    n_checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_resp: busy=%b valid=%b expected 0 0", o_busy, o_valid); end
    @(negedge i_clk); i_rst = 1; dmem.dmem_rvalid = 1; dmem.dmem_gnt = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      n_checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL late_rvalid[%0d]: valid=%b busy=%b expected 0 0", c, o_valid, o_busy); end
    end
    dmem.dmem_rvalid = 0; dmem.dmem_gnt = 0;
    i_valid = 1; mem_write = 1; funct3 = 3'b010; addr = 32'h80;
    @(negedge i_clk); i_valid = 0; mem_write = 0;
    n_checks++; if (dmem.dmem_req !== 1'b1) begin n_fail++; $display("FAIL req_raised: req=%b expected 1", dmem.dmem_req); end
    #2 i_rst = 0; #1;
    n_checks++; if (dmem.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_drops_req: req=%b expected 0", dmem.dmem_req); end
    @(negedge i_clk); i_rst = 1;
    @(negedge i_clk);
  endtask

  initial begin
    dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0; dmem.dmem_rdata = '0;
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_timeout();
    test_misaligned();
    test_back_to_back();
    test_reset_during_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
